// File: rtl/mem_arbiter.sv
// Two-master (fetch / data) arbiter in front of the single-port RAM; grant is
// registered, muxing is combinational. Define ARB_ROUND_ROBIN_EN for fair ties.
module mem_arbiter #(
  parameter int MEM_DEPTH = 4096,
  parameter int IDX_W     = $clog2(MEM_DEPTH) - 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req,
  input  logic [63:0]      if_addr,
  output logic [31:0]      if_rdata,
  output logic             if_valid,
  input  logic             d_ren,
  input  logic             d_wen,
  input  logic [63:0]      d_addr,
  input  logic [63:0]      d_wdata,
  input  logic [7:0]       d_wmask,
  output logic [63:0]      d_rdata,
  output logic             d_valid,
  output logic             ram_ren,
  output logic             ram_wen,
  output logic [IDX_W-1:0] ram_addr,
  output logic [63:0]      ram_wdata,
  output logic [7:0]       ram_wmask,
  input  logic [63:0]      ram_rdata,
  input  logic             ram_valid
);

  typedef enum logic [1:0] {IDLE, GNT_IF, GNT_D} state_t;

  state_t state, pick;
  logic   d_req, d_wins_tie, gnt_if, gnt_d;
  logic   unused_addr_bits;

  assign d_req = d_ren | d_wen;
  assign unused_addr_bits = ^{if_addr[63:IDX_W+3], if_addr[1:0],
                              d_addr[63:IDX_W+3], d_addr[2:0]};

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d;

  always_ff @(posedge clk) begin
    if (rst)                                last_d <= 1'b0;
    else if (ram_valid && state == GNT_D)   last_d <= 1'b1;
    else if (ram_valid && state == GNT_IF)  last_d <= 1'b0;
  end

  assign d_wins_tie = ~last_d;
`else
  assign d_wins_tie = 1'b1;
`endif

  always_comb begin
    pick = IDLE;
    if (d_req && (!if_req || d_wins_tie)) pick = GNT_D;
    else if (if_req)                      pick = GNT_IF;
  end

  // Completion wins over a dropped request; otherwise a drop aborts to IDLE.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else begin
      case (state)
        IDLE:    state <= pick;
        GNT_IF:  if (ram_valid)   state <= pick;
                 else if (!if_req) state <= IDLE;
        GNT_D:   if (ram_valid)   state <= pick;
                 else if (!d_req)  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Reset masks the grant in the same cycle so nothing leaks while rst is high.
  assign gnt_if = (state == GNT_IF) & ~rst;
  assign gnt_d  = (state == GNT_D)  & ~rst;

  assign ram_ren   = gnt_if | (gnt_d & d_ren & ~d_wen);
  assign ram_wen   = gnt_d & d_wen;
  assign ram_addr  = gnt_if ? if_addr[IDX_W+2:3] :
                     gnt_d  ? d_addr[IDX_W+2:3]  : '0;
  assign ram_wdata = gnt_d ? d_wdata : 64'h0;
  assign ram_wmask = gnt_d ? d_wmask : 8'h0;

  assign if_valid = gnt_if & ram_valid;
  assign d_valid  = gnt_d & ram_valid;
  assign if_rdata = if_addr[2] ? ram_rdata[63:32] : ram_rdata[31:0];
  assign d_rdata  = ram_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic, checked every
// cycle against an ownership model and a 1-cycle RAM model.
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int MEM_DEPTH = 4096;
  localparam int IDX_W     = $clog2(MEM_DEPTH) - 3;
  localparam int WORDS     = MEM_DEPTH / 8;

  logic clk = 1'b0, rst = 1'b1;
  logic if_req = 1'b0, d_ren = 1'b0, d_wen = 1'b0;
  logic [63:0] if_addr = '0, d_addr = '0, d_wdata = '0;
  logic [7:0]  d_wmask = '0;
  logic [31:0] if_rdata;
  logic [63:0] d_rdata;
  logic if_valid, d_valid, ram_ren, ram_wen;
  logic [IDX_W-1:0] ram_addr;
  logic [63:0] ram_wdata;
  logic [7:0]  ram_wmask;
  logic [63:0] ram_rdata = '0;
  logic        ram_valid = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_DEPTH(MEM_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wmask(d_wmask), .d_rdata(d_rdata), .d_valid(d_valid),
    .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_wmask(ram_wmask),
    .ram_rdata(ram_rdata), .ram_valid(ram_valid)
  );

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // RAM model: accepts a request, answers one cycle later, never twice in a row.
  function automatic logic [63:0] init_word(int i);
    if (i == 5) return 64'h1122334455667788;
    if (i == 8) return 64'hDEADBEEFCAFEF00D;
    return {32'h5A5A0000 ^ 32'(i), ~32'(i)};
  endfunction

  logic [63:0] mem [WORDS];
  always @(posedge clk) begin
    if (rst) begin
      ram_valid <= 1'b0;
      for (int i = 0; i < WORDS; i++) mem[i] <= init_word(i);
    end else if ((ram_ren | ram_wen) && !ram_valid) begin
      ram_valid <= 1'b1;
      ram_rdata <= mem[ram_addr];
      if (ram_wen)
        for (int b = 0; b < 8; b++)
          if (ram_wmask[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end else begin
      ram_valid <= 1'b0;
    end
  end

  // Reference model: who owns the memory this cycle.
  typedef enum logic [1:0] {M_NONE, M_IF, M_D} own_t;
  own_t m_own = M_NONE;
  own_t m_pick;
  wire  d_any = d_ren | d_wen;

`ifdef ARB_ROUND_ROBIN_EN
  logic m_last_d = 1'b0;
  wire  d_first = !m_last_d;
  always @(posedge clk) begin
    if (rst) m_last_d <= 1'b0;
    else if (m_own != M_NONE && ram_valid) m_last_d <= (m_own == M_D);
  end
`else
  wire  d_first = 1'b1;
`endif

  always_comb begin
    m_pick = M_NONE;
    if (d_any && if_req) m_pick = d_first ? M_D : M_IF;
    else if (d_any)      m_pick = M_D;
    else if (if_req)     m_pick = M_IF;
  end

  always @(posedge clk) begin
    if (rst)                                   m_own <= M_NONE;
    else if (m_own == M_NONE || ram_valid)     m_own <= m_pick;
    else if (m_own == M_IF && !if_req)         m_own <= M_NONE;
    else if (m_own == M_D && !d_any)           m_own <= M_NONE;
  end

  logic e_ren, e_wen, e_ifv, e_dv;
  logic [IDX_W-1:0] e_addr;
  logic [63:0] e_wdata;
  logic [7:0]  e_wmask;
  logic [IDX_W-1:0] f_idx, d_idx;
  logic [31:0] e_if_rdata;

  assign f_idx = IDX_W'(if_addr >> 3);
  assign d_idx = IDX_W'(d_addr >> 3);
  assign e_if_rdata = 32'(mem[f_idx] >> (if_addr[2] ? 32 : 0));

  always_comb begin
    e_ren = 1'b0; e_wen = 1'b0; e_ifv = 1'b0; e_dv = 1'b0;
    e_addr = '0; e_wdata = '0; e_wmask = '0;
    if (!rst && m_own == M_IF) begin
      e_ren = 1'b1; e_addr = f_idx; e_ifv = ram_valid;
    end else if (!rst && m_own == M_D) begin
      e_wen = d_wen; e_ren = d_ren && !d_wen; e_addr = d_idx;
      e_wdata = d_wdata; e_wmask = d_wmask; e_dv = ram_valid;
    end
  end

  always @(negedge clk) begin
    chk("ram_ren",   64'(ram_ren),   64'(e_ren));
    chk("ram_wen",   64'(ram_wen),   64'(e_wen));
    chk("ram_addr",  64'(ram_addr),  64'(e_addr));
    chk("ram_wdata", ram_wdata,      e_wdata);
    chk("ram_wmask", 64'(ram_wmask), 64'(e_wmask));
    chk("if_valid",  64'(if_valid),  64'(e_ifv));
    chk("d_valid",   64'(d_valid),   64'(e_dv));
    if (e_ifv) chk("if_rdata", 64'(if_rdata), 64'(e_if_rdata));
    if (e_dv && !d_wen) chk("d_rdata", d_rdata, mem[d_idx]);
  end

  // Directed helpers
  task automatic wait_valid(input bit is_d, output int lat);
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (is_d ? d_valid : if_valid) begin lat = c; break; end
    end
  endtask

  task automatic do_fetch(input logic [63:0] a, output logic [31:0] data, output int lat);
    @(negedge clk); #1;
    if_req = 1'b1; if_addr = a;
    wait_valid(1'b0, lat);
    data = if_rdata;
    #1 if_req = 1'b0;
  endtask

  task automatic do_data(input bit wen, input logic [63:0] a, input logic [63:0] wd,
                         input logic [7:0] m, output logic [63:0] data, output int lat);
    @(negedge clk); #1;
    d_wen = wen; d_ren = !wen; d_addr = a; d_wdata = wd; d_wmask = m;
    wait_valid(1'b1, lat);
    data = d_rdata;
    #1 begin d_wen = 1'b0; d_ren = 1'b0; end
  endtask

  task automatic do_reset();
    @(negedge clk); #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
  endtask

  logic [31:0] fd;
  logic [63:0] dd;
  int lat, nd, ni;
  bit exp_v, exp_d;
  bit fv, f_abort, dvs, d_abort;
  int f_age, d_age;

  initial begin
    // reset held with a pending fetch
    if_req = 1'b1; if_addr = 64'h2C;
    repeat (3) @(negedge clk);
    chk("rst_ram_ren", 64'(ram_ren), 64'd0);
    chk("rst_if_valid", 64'(if_valid), 64'd0);
    chk("rst_ram_addr", 64'(ram_addr), 64'd0);
    #1 rst = 1'b0;
    @(negedge clk); chk("rel_c1_ren", 64'(ram_ren), 64'd1);
    @(negedge clk); chk("rel_c2_ifv", 64'(if_valid), 64'd1);
    chk("rel_c2_rdata", 64'(if_rdata), 64'h11223344);
    #1 if_req = 1'b0;

    do_fetch(64'h2C, fd, lat);
    chk("fetch_2c", 64'(fd), 64'h11223344); chk("fetch_2c_lat", 64'(lat), 64'd2);
    do_fetch(64'h28, fd, lat);
    chk("fetch_28", 64'(fd), 64'h55667788); chk("fetch_28_lat", 64'(lat), 64'd2);

    do_data(1'b1, 64'h40, 64'hAABBCCDDEEFF0011, 8'h0F, dd, lat);
    chk("write_lat", 64'(lat), 64'd2);
    do_data(1'b0, 64'h40, 64'h0, 8'h0, dd, lat);
    chk("read_back", dd, 64'hDEADBEEFEEFF0011); chk("read_lat", 64'(lat), 64'd2);

    // both ports requesting continuously
    do_reset();
    @(negedge clk); #1;
    if_req = 1'b1; if_addr = 64'h28; d_ren = 1'b1; d_addr = 64'h40;
    nd = 0; ni = 0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      exp_v = (c % 2 == 0);
`ifdef ARB_ROUND_ROBIN_EN
      exp_d = exp_v && ((c / 2) % 2 == 1);
`else
      exp_d = exp_v;
`endif
      chk("tie_d_valid", 64'(d_valid), 64'(exp_d));
      chk("tie_if_valid", 64'(if_valid), 64'(exp_v && !exp_d));
      nd += int'(d_valid); ni += int'(if_valid);
    end
    #1 begin if_req = 1'b0; d_ren = 1'b0; end
`ifdef ARB_ROUND_ROBIN_EN
    chk("tie_d_count", 64'(nd), 64'd4); chk("tie_if_count", 64'(ni), 64'd4);
`else
    chk("tie_d_count", 64'(nd), 64'd8); chk("tie_if_count", 64'(ni), 64'd0);
`endif

    // fetch abort with a data read waiting behind it
    do_reset();
    @(negedge clk); #1 begin if_req = 1'b1; if_addr = 64'h28; end
    @(negedge clk); chk("abort_c1_ren", 64'(ram_ren), 64'd1);
    #1 begin if_req = 1'b0; d_ren = 1'b1; d_addr = 64'h40; end
    @(negedge clk); chk("abort_c2_ren", 64'(ram_ren), 64'd0);
    chk("abort_c2_ifv", 64'(if_valid), 64'd0);
    @(negedge clk); chk("abort_c3_ren", 64'(ram_ren), 64'd1);
    chk("abort_c3_addr", 64'(ram_addr), 64'd8);
    @(negedge clk); chk("abort_c4_dv", 64'(d_valid), 64'd1);
    chk("abort_c4_rdata", d_rdata, 64'hDEADBEEFCAFEF00D);
    #1 d_ren = 1'b0;

    // reset while a write is granted
    do_reset();
    @(negedge clk); #1 begin d_wen = 1'b1; d_addr = 64'h40; d_wdata = 64'h1; d_wmask = 8'hFF; end
    @(negedge clk); chk("rstw_c1_wen", 64'(ram_wen), 64'd1);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); chk("rstw_c2_wen", 64'(ram_wen), 64'd0);
    chk("rstw_c2_dv", 64'(d_valid), 64'd0);
    wait_valid(1'b1, lat);
    chk("rstw_regrant_lat", 64'(lat), 64'd2);
    #1 d_wen = 1'b0;

    // random traffic from both masters
    fork
      begin
        f_age = 0; f_abort = 1'b0;
        for (int n = 0; n < 4000; n++) begin
          @(negedge clk); fv = if_valid; #1;
          if (if_req) begin
            f_age++;
            if (fv || (f_abort && f_age == 1)) begin
              if_req = 1'b0;
              if (fv && $urandom_range(0, 1) == 1) begin
                if_req = 1'b1; if_addr = {$urandom, $urandom};
                f_age = 0; f_abort = ($urandom_range(0, 7) == 0);
              end
            end
          end else if ($urandom_range(0, 3) == 0) begin
            if_req = 1'b1; if_addr = {$urandom, $urandom};
            f_age = 0; f_abort = ($urandom_range(0, 7) == 0);
          end
        end
      end
      begin
        d_age = 0; d_abort = 1'b0;
        for (int n = 0; n < 4000; n++) begin
          @(negedge clk); dvs = d_valid; #1;
          if (d_ren | d_wen) begin
            d_age++;
            if (dvs || (d_abort && d_age == 1)) begin
              d_ren = 1'b0; d_wen = 1'b0;
            end
          end else if ($urandom_range(0, 2) == 0) begin
            case ($urandom_range(0, 2))
              0:       begin d_ren = 1'b1; d_wen = 1'b0; end
              1:       begin d_ren = 1'b0; d_wen = 1'b1; end
              default: begin d_ren = 1'b1; d_wen = 1'b1; end
            endcase
            d_addr = {$urandom, $urandom}; d_wdata = {$urandom, $urandom};
            d_wmask = 8'($urandom);
            d_age = 0; d_abort = ($urandom_range(0, 7) == 0);
          end
        end
      end
    join
    @(negedge clk); #1 begin if_req = 1'b0; d_ren = 1'b0; d_wen = 1'b0; end
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
